// File: rtl/cpu_icache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
`timescale 1ns/1ps
package cpu_icache_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  localparam int unsigned ADDR_W = 32;

  // ceil(log2(v)) for elaboration-time width derivation
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned tag_width(input int unsigned size, input int unsigned ob);
    return ADDR_W - 2 - ob - size;
  endfunction

  // Extract w bits of pc starting at bit lsb, zero-extended
  function automatic logic [ADDR_W-1:0] pc_field(input logic [ADDR_W-1:0] pc,
                                                 input int unsigned lsb,
                                                 input int unsigned w);
    return (pc >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/cpu_icache_way.sv
// One cache way: per-set tag, valid bit and line words held in flops.
`timescale 1ns/1ps
module cpu_icache_way #(
  parameter int unsigned SIZE       = 3,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAGW       = 25,
  parameter int unsigned OBW        = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [SIZE-1:0] i_rd_index,
  input  logic [OBW-1:0]  i_rd_offset,
  output logic            o_valid,
  output logic [TAGW-1:0] o_tag,
  output logic [31:0]     o_word,
  input  logic            i_wr_en,
  input  logic [SIZE-1:0] i_wr_index,
  input  logic [OBW-1:0]  i_wr_offset,
  input  logic [31:0]     i_wr_data,
  input  logic            i_tag_we,
  input  logic [TAGW-1:0] i_wr_tag,
  input  logic            i_clr_en,
  input  logic [SIZE-1:0] i_clr_index,
  input  logic            i_flush
);

  localparam int unsigned SETS = 1 << SIZE;

  logic [SETS-1:0] r_valid;
  logic [TAGW-1:0] r_tag  [SETS];
  logic [31:0]     r_data [SETS][LINE_WORDS];

  // Valid bits: flush beats line validation, validation beats single-set clear
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end else if (i_clr_en) begin
      r_valid[i_clr_index] <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_data[i_wr_index][i_wr_offset] <= i_wr_data;
    if (i_tag_we) r_tag[i_wr_index] <= i_wr_tag;
  end

  assign o_valid = r_valid[i_rd_index];
  assign o_tag   = r_tag[i_rd_index];
  assign o_word  = r_data[i_rd_index][i_rd_offset];

endmodule

// File: rtl/cpu_icache_assoc.sv
// Set-associative instruction cache: zero-latency hit lookup, round-robin refill, fence.i flush.
`timescale 1ns/1ps
module cpu_icache_assoc
  import cpu_icache_pkg::*;
#(
  parameter int unsigned SIZE       = 3,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_input_pc,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  input  logic        i_invalidate,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic        o_hit,
  output logic        o_miss
);

  localparam int unsigned OB   = log2c(LINE_WORDS);
  localparam int unsigned OBW  = (OB == 0) ? 1 : OB;
  localparam int unsigned SETS = 1 << SIZE;
  localparam int unsigned TAGW = tag_width(SIZE, OB);
  localparam int unsigned WW   = (WAYS > 1) ? log2c(WAYS) : 1;

  state_e          r_state;
  state_e          w_state_next;
  logic [TAGW-1:0] r_tag;
  logic [SIZE-1:0] r_index;
  logic [WW-1:0]   r_victim;
  logic [OBW-1:0]  r_beat;
  logic            r_flush;
  logic [WW-1:0]   r_rr [SETS];

  logic [OBW-1:0]  w_offset;
  logic [SIZE-1:0] w_index;
  logic [TAGW-1:0] w_tag;
  logic [WW-1:0]   w_victim;
  logic [WAYS-1:0] w_valid;
  logic [WAYS-1:0] w_match;
  logic [TAGW-1:0] w_way_tag  [WAYS];
  logic [31:0]     w_way_word [WAYS];
  logic [31:0]     w_hit_word;
  logic            w_hit;
  logic [31:0]     w_beat_addr;
  logic            w_miss_start;
  logic            w_beat_we;
  logic            w_last;
  logic            w_line_we;
  logic            w_flush_all;

  assign w_offset = (OB == 0) ? '0 : OBW'(pc_field(i_input_pc, 2, OB));
  assign w_index  = SIZE'(pc_field(i_input_pc, OB + 2, SIZE));
  assign w_tag    = TAGW'(pc_field(i_input_pc, OB + 2 + SIZE, TAGW));
  assign w_victim = r_rr[w_index];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cpu_icache_way #(
      .SIZE(SIZE), .LINE_WORDS(LINE_WORDS), .TAGW(TAGW), .OBW(OBW)
    ) u_way (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_rd_index  (w_index),
      .i_rd_offset (w_offset),
      .o_valid     (w_valid[g]),
      .o_tag       (w_way_tag[g]),
      .o_word      (w_way_word[g]),
      .i_wr_en     (w_beat_we && (r_victim == WW'(g))),
      .i_wr_index  (r_index),
      .i_wr_offset (r_beat),
      .i_wr_data   (i_bus_rdata),
      .i_tag_we    (w_line_we && (r_victim == WW'(g))),
      .i_wr_tag    (r_tag),
      .i_clr_en    (w_miss_start && (w_victim == WW'(g))),
      .i_clr_index (w_index),
      .i_flush     (w_flush_all)
    );
    assign w_match[g] = w_valid[g] && (w_way_tag[g] == w_tag);
  end

  // A hit needs exactly one matching way
  assign w_hit = (w_match != '0) && ((w_match & (w_match - WAYS'(1))) == '0);

  always_comb begin
    w_hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_match[w]) w_hit_word = w_hit_word | w_way_word[w];
    end
  end

  // Line base and beat offset are concatenated so the beat count never carries into the tag
  assign w_beat_addr = (32'({r_tag, r_index}) << (OB + 2))
                     | ((OB == 0) ? 32'd0 : (32'(r_beat) << 2));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_miss_start) w_state_next = REFILL;
      REFILL:  if (w_last)       w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready       = 1'b0;
    o_hit         = 1'b0;
    o_miss        = 1'b0;
    o_rdata       = '0;
    o_bus_request = 1'b0;
    o_bus_address = '0;
    w_miss_start  = 1'b0;
    w_beat_we     = 1'b0;
    w_last        = 1'b0;
    w_line_we     = 1'b0;
    w_flush_all   = 1'b0;
    if (i_reset) begin
      unique case (r_state)
        IDLE: begin
          if (i_invalidate) begin
            w_flush_all = 1'b1;
          end else if (i_request && w_hit) begin
            o_ready = 1'b1;
            o_hit   = 1'b1;
            o_rdata = w_hit_word;
          end else if (i_request) begin
            o_miss       = 1'b1;
            w_miss_start = 1'b1;
          end
        end
        REFILL: begin
          o_bus_request = 1'b1;
          o_bus_address = w_beat_addr;
          w_beat_we     = i_bus_ready;
          w_last        = i_bus_ready && (r_beat == OBW'(LINE_WORDS - 1));
          // A flush seen at any point of the refill (including the last beat) discards the line
          w_line_we     = w_last && !r_flush && !i_invalidate;
          w_flush_all   = w_last && (r_flush || i_invalidate);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tag    <= '0;
      r_index  <= '0;
      r_victim <= '0;
      r_beat   <= '0;
      r_flush  <= 1'b0;
    end else if (w_miss_start) begin
      r_tag    <= w_tag;
      r_index  <= w_index;
      r_victim <= w_victim;
      r_beat   <= '0;
      r_flush  <= 1'b0;
    end else if (r_state == REFILL) begin
      if (i_bus_ready) r_beat <= r_beat + OBW'(1);
      if (w_last)            r_flush <= 1'b0;
      else if (i_invalidate) r_flush <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else if (w_last) begin
      r_rr[r_index] <= (WAYS == 1) ? '0 : r_rr[r_index] + WW'(1);
    end
  end

endmodule
